// File: rtl/alu_result_latch_if.sv
// Handshake bundle between the ALU, the result latch and the data bus.
// Also holds the flag bit positions shared by the latch and its users.
`ifndef CARRY_FLAG
`define CARRY_FLAG 0
`endif
`ifndef ZERO_FLAG
`define ZERO_FLAG 1
`endif
`ifndef NEG_FLAG
`define NEG_FLAG 2
`endif
`ifndef REM_FLAG
`define REM_FLAG 3
`endif

interface alu_result_latch_if;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags;
  logic        in_valid;
  logic        in_ready;
  logic        bus_valid;
  logic        bus_ready;
  logic [7:0]  bus_data;
  logic        bus_hi;

  modport master (
    output alu_out, alu_flags, in_valid, bus_ready,
    input  in_ready, bus_valid, bus_data, bus_hi
  );

  modport slave (
    input  alu_out, alu_flags, in_valid, bus_ready,
    output in_ready, bus_valid, bus_data, bus_hi
  );
endinterface

// File: rtl/alu_result_latch.sv
// ALU latch stage: result FIFO toward the data bus plus the architectural flag register.
// Define ALU_LATCH_WIDE_EN to store the high byte and drain each entry in two beats.
module alu_result_latch #(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  alu_result_latch_if.slave io,
  input  logic             flush,
  output logic [3:0]       flags_q,
  output logic [PTR_W:0]   count
);

`ifdef ALU_LATCH_WIDE_EN
  localparam int ENTRY_W = 16;
`else
  localparam int ENTRY_W = 8;
`endif
  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               beat;
  logic               pop;
  logic               unused_bits;

  function automatic logic [3:0] next_flags(input logic carry, input logic neg,
                                            input logic [7:0] lo);
    logic [3:0] f;
    f = 4'b0000;
    f[`CARRY_FLAG] = carry;
    f[`NEG_FLAG]   = neg;
    f[`ZERO_FLAG]  = (lo == 8'h00);
    return f;
  endfunction

  // Ready/valid come straight from the registered occupancy, so a full FIFO
  // refuses a push even when the bus drains an entry on the same edge.
  assign io.in_ready  = (count != FULL);
  assign io.bus_valid = (count != '0);
  assign push         = io.in_valid & io.in_ready;
  assign beat         = io.bus_valid & io.bus_ready;
  assign head         = mem[rd_ptr];

`ifdef ALU_LATCH_WIDE_EN
  logic phase;

  assign pop         = beat & phase;
  assign io.bus_hi   = phase;
  assign io.bus_data = io.bus_valid ? (phase ? head[15:8] : head[7:0]) : 8'h00;
  assign unused_bits = ^{io.alu_flags[`ZERO_FLAG], io.alu_flags[`REM_FLAG]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase <= 1'b0;
    end else if (flush) begin
      phase <= 1'b0;
    end else if (beat) begin
      phase <= ~phase;
    end
  end
`else
  assign pop         = beat;
  assign io.bus_hi   = 1'b0;
  assign io.bus_data = io.bus_valid ? head : 8'h00;
  assign unused_bits = ^{io.alu_flags[`ZERO_FLAG], io.alu_flags[`REM_FLAG],
                         io.alu_out[15:8]};
`endif

  // Storage is data-only; stale entries are never visible because bus_data is gated by count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= io.alu_out[ENTRY_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      flags_q <= 4'b0000;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        flags_q <= next_flags(io.alu_flags[`CARRY_FLAG], io.alu_flags[`NEG_FLAG],
                              io.alu_out[7:0]);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
